// File: rtl/key_pkg.sv
// Shared types and helpers for the key click decoder.
package key_pkg;

    // Two-state grouping FSM: idle, or waiting for more strobes in the window.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } click_state_t;

    // Width needed to hold a click count of 0..max_clicks.
    function automatic int clicks_w(input int max_clicks);
        return $clog2(max_clicks + 1);
    endfunction

endpackage

// File: rtl/key_window_timer.sv
// Restartable window timer: counts enabled cycles from zero and flags the
// final tick of the window. Clear takes priority over enable.
module key_window_timer #(
    parameter int WINDOW_TICKS = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int TW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;

    logic [TW-1:0] timer_q;

    // Timer register: restart on clear, otherwise advance while enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else if (clear_i) begin
            timer_q <= '0;
        end else if (enable_i) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // The window ends on the cycle the timer sits at its last value.
    assign expired_o = (timer_q == TW'(WINDOW_TICKS - 1));

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced key-press strobes that arrive within a time window into a
// single click event (single/double/triple...) and presents it through a
// one-entry valid/ready holding register. Events that find the register
// occupied are dropped and reported with a one-cycle pulse.
module key_click_decoder
    import key_pkg::*;
#(
    parameter  int CLK_FREQ_MHZ    = 10,
    parameter  int CLICK_WINDOW_US = 300000,
    parameter  int MAX_CLICKS      = 3,
    localparam int CW              = clicks_w(MAX_CLICKS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          key_pressed_stb_i,
    output logic          event_valid_o,
    input  logic          event_ready_i,
    output logic [CW-1:0] event_clicks_o,
    output logic          busy_o,
    output logic          drop_stb_o
);

    localparam int WINDOW_TICKS = CLICK_WINDOW_US * CLK_FREQ_MHZ;

    if (WINDOW_TICKS < 2) begin : g_bad_window
        $error("key_click_decoder: WINDOW_TICKS must be at least 2");
    end
    if (MAX_CLICKS < 1) begin : g_bad_max
        $error("key_click_decoder: MAX_CLICKS must be at least 1");
    end

    click_state_t  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          timer_clear;
    logic          timer_en;
    logic          timer_expired;
    logic          emit;

    logic          valid_q, valid_d;
    logic [CW-1:0] clicks_q, clicks_d;
    logic          drop_q, drop_d;
    logic          pop;

    key_window_timer #(
        .WINDOW_TICKS (WINDOW_TICKS)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    // FSM and click-count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: a strobe always restarts the window, so a strobe on
    // the expiry cycle extends the group instead of closing it.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        emit        = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (key_pressed_stb_i) begin
                    state_d = WAIT;
                    count_d = CW'(1);
                end
            end
            WAIT: begin
                if (key_pressed_stb_i) begin
                    timer_clear = 1'b1;
                    if (count_q != CW'(MAX_CLICKS)) begin
                        count_d = count_q + CW'(1);
                    end
                end else if (timer_expired) begin
                    emit        = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = IDLE;
                    count_d     = '0;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Output holding register and drop pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            clicks_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            clicks_q <= clicks_d;
            drop_q   <= drop_d;
        end
    end

    // Load on emit when the slot is free or being drained this cycle;
    // otherwise keep the held event and flag the loss.
    always_comb begin
        valid_d  = valid_q;
        clicks_d = clicks_q;
        drop_d   = 1'b0;
        pop      = valid_q & event_ready_i;
        if (emit) begin
            if (!valid_q || pop) begin
                valid_d  = 1'b1;
                clicks_d = count_q;
            end else begin
                drop_d = 1'b1;
            end
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    assign event_valid_o  = valid_q;
    assign event_clicks_o = clicks_q;
    assign drop_stb_o     = drop_q;
    assign busy_o         = (state_q == WAIT);

endmodule

// File: tb/tb_key_click_decoder.sv
// Self-checking bench for key_click_decoder with a 20-tick window.
// Expected events come from a small grouping model and wait in a scoreboard
// queue until the DUT presents an event.
module tb_key_click_decoder;

    localparam int WIN = 20;
    localparam int MAXC = 3;

    logic       clk;
    logic       rst;
    logic       stb;
    logic       ready;
    logic       valid;
    logic [1:0] clicks;
    logic       busy;
    logic       drop;

    typedef struct {
        int edge_no;
        int clicks;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   edge_k = 0;
    logic new_ev = 1'b0;

    key_click_decoder #(
        .CLK_FREQ_MHZ    (10),
        .CLICK_WINDOW_US (2),
        .MAX_CLICKS      (MAXC)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .key_pressed_stb_i (stb),
        .event_valid_o     (valid),
        .event_ready_i     (ready),
        .event_clicks_o    (clicks),
        .busy_o            (busy),
        .drop_stb_o        (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grouping model: strobes more than WIN edges apart start a new group;
    // each group emits WIN edges after its last strobe with a saturated count.
    function automatic void model_push(input logic [127:0] m, input int n);
        int   cnt = 0;
        int   last = 0;
        exp_t x;
        for (int e = 1; e <= n; e++) begin
            if (m[e]) begin
                if (cnt > 0 && (e - last) > WIN) begin
                    x.edge_no = last + WIN;
                    x.clicks  = (cnt > MAXC) ? MAXC : cnt;
                    sb.push_back(x);
                    cnt = 0;
                end
                cnt++;
                last = e;
            end
        end
        if (cnt > 0) begin
            x.edge_no = last + WIN;
            x.clicks  = (cnt > MAXC) ? MAXC : cnt;
            sb.push_back(x);
        end
    endfunction

    // Drive inputs for the coming edge, step one edge, sample 1 time unit
    // later and flag whether a fresh event has appeared on the output.
    task automatic tick(input logic s, input logic r);
        logic was_valid;
        logic hs;
        @(negedge clk);
        stb       = s;
        ready     = r;
        was_valid = valid;
        hs        = valid & r;
        @(posedge clk);
        edge_k++;
        #1;
        new_ev = valid && (!was_valid || hs);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        stb   = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, clicks, busy, drop} !== 5'b0)
            $display("FAIL reset_outputs: got valid=%b clicks=%0d busy=%b drop=%b, want all 0",
                     valid, clicks, busy, drop);
        else passed++;
        stb = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, busy} !== 2'b0)
            $display("FAIL reset_idle: got valid=%b busy=%b, want 0 0", valid, busy);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [127:0] m = '0;
        exp_t x;
        m[5] = 1'b1;
        model_push(m, 40);
        edge_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(m[k], 1'b1);
            checks++;
            if (busy !== (k >= 5 && k <= 24))
                $display("FAIL single_busy edge %0d: got %b want %b", k, busy, (k >= 5 && k <= 24));
            else passed++;
            if (new_ev) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL single_unexpected edge %0d: got event clicks=%0d, want none", k, clicks);
                end else begin
                    x = sb.pop_front();
                    if (k !== x.edge_no || int'(clicks) !== x.clicks)
                        $display("FAIL single_event: got edge %0d clicks %0d, want edge %0d clicks %0d",
                                 k, clicks, x.edge_no, x.clicks);
                    else passed++;
                end
            end
        end
        checks++;
        if (sb.size() != 0) $display("FAIL single_missing: got %0d pending events, want 0", sb.size());
        else passed++;
        sb.delete();
        $display("test_single done");
    endtask

    // Grouping scenarios with ready held high: double, saturated triple,
    // strobe exactly on expiry, and a gap one edge too long (two events).
    task automatic test_groups();
        logic [127:0] m;
        exp_t x;
        for (int sc = 0; sc < 4; sc++) begin
            m = '0;
            case (sc)
                0: begin m[5] = 1'b1; m[15] = 1'b1; end
                1: for (int j = 5; j <= 25; j += 5) m[j] = 1'b1;
                2: begin m[5] = 1'b1; m[25] = 1'b1; end
                default: begin m[5] = 1'b1; m[26] = 1'b1; end
            endcase
            model_push(m, 60);
            edge_k = 0;
            for (int k = 1; k <= 60; k++) begin
                tick(m[k], 1'b1);
                if (new_ev) begin
                    checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL groups%0d_unexpected edge %0d: got clicks=%0d, want no event",
                                 sc, k, clicks);
                    end else begin
                        x = sb.pop_front();
                        if (k !== x.edge_no || int'(clicks) !== x.clicks)
                            $display("FAIL groups%0d_event: got edge %0d clicks %0d, want edge %0d clicks %0d",
                                     sc, k, clicks, x.edge_no, x.clicks);
                        else passed++;
                    end
                end
                if (drop !== 1'b0) begin
                    checks++;
                    $display("FAIL groups%0d_drop edge %0d: got 1 want 0", sc, k);
                end
            end
            checks++;
            if (sb.size() != 0)
                $display("FAIL groups%0d_missing: got %0d pending events, want 0", sc, sb.size());
            else passed++;
            sb.delete();
            $display("test_groups scenario %0d done", sc);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] m = '0;
        exp_t x;
        m[5]  = 1'b1;
        m[40] = 1'b1;
        x.edge_no = 5 + WIN;
        x.clicks  = 1;
        sb.push_back(x);  // the second group (edge 60) is dropped: slot full
        edge_k = 0;
        for (int k = 1; k <= 80; k++) begin
            tick(m[k], (k >= 70));
            checks++;
            if (drop !== (k == 60)) $display("FAIL bp_drop edge %0d: got %b want %b", k, drop, (k == 60));
            else passed++;
            checks++;
            if (valid !== (k >= 25 && k < 70))
                $display("FAIL bp_valid edge %0d: got %b want %b", k, valid, (k >= 25 && k < 70));
            else passed++;
            if (k >= 25 && k < 70) begin
                checks++;
                if (clicks !== 2'd1) $display("FAIL bp_clicks_stable edge %0d: got %0d want 1", k, clicks);
                else passed++;
            end
            if (new_ev) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL bp_unexpected edge %0d: got clicks=%0d, want none", k, clicks);
                end else begin
                    x = sb.pop_front();
                    if (k !== x.edge_no || int'(clicks) !== x.clicks)
                        $display("FAIL bp_event: got edge %0d clicks %0d, want edge %0d clicks %0d",
                                 k, clicks, x.edge_no, x.clicks);
                    else passed++;
                end
            end
        end
        checks++;
        if (sb.size() != 0) $display("FAIL bp_missing: got %0d pending events, want 0", sb.size());
        else passed++;
        sb.delete();
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid_group();
        logic [127:0] m = '0;
        exp_t x;
        m[5]  = 1'b1;
        m[40] = 1'b1;
        sb.delete();
        x.edge_no = 40 + WIN;  // the first group is killed by the reset
        x.clicks  = 1;
        sb.push_back(x);
        edge_k = 0;
        for (int k = 1; k <= 70; k++) begin
            if (k == 12) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy);
                else passed++;
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({valid, clicks, busy, drop} !== 5'b0)
                    $display("FAIL rstmid_async: got valid=%b clicks=%0d busy=%b drop=%b, want all 0",
                             valid, clicks, busy, drop);
                else passed++;
                rst = 1'b0;
            end
            tick(m[k], 1'b1);
            if (new_ev) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rstmid_unexpected edge %0d: got clicks=%0d, want none", k, clicks);
                end else begin
                    x = sb.pop_front();
                    if (k !== x.edge_no || int'(clicks) !== x.clicks)
                        $display("FAIL rstmid_event: got edge %0d clicks %0d, want edge %0d clicks %0d",
                                 k, clicks, x.edge_no, x.clicks);
                    else passed++;
                end
            end
        end
        checks++;
        if (sb.size() != 0) $display("FAIL rstmid_missing: got %0d pending events, want 0", sb.size());
        else passed++;
        sb.delete();
        $display("test_reset_mid_group done");
    endtask

    initial begin
        rst   = 1'b1;
        stb   = 1'b0;
        ready = 1'b1;
        test_reset();
        test_single();
        test_groups();
        test_backpressure();
        test_reset_mid_group();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
